// File: rtl/video_pkg.sv
// Shared video types and default 15 kHz PAL raster timing.
// The scandoubler derives its CLKVIDEO-based counts from these too.
package video_pkg;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } rgb333_t;

    localparam int CNT_W            = 9;

    localparam int PAL_H_TOTAL      = 384;
    localparam int PAL_H_ACTIVE     = 256;
    localparam int PAL_H_SYNC_START = 304;
    localparam int PAL_H_SYNC_LEN   = 28;
    localparam int PAL_V_TOTAL      = 312;
    localparam int PAL_V_ACTIVE     = 208;
    localparam int PAL_V_SYNC_START = 256;
    localparam int PAL_V_SYNC_LINES = 3;

endpackage

// File: rtl/video_sync_counter.sv
// Raster h/v counters and the stage-0 decode of active, syncs and frame start.
// Vsync opens and closes on hsync leading edges, so it may span line boundaries.
module video_sync_counter
    import video_pkg::*;
#(
    parameter int H_TOTAL      = PAL_H_TOTAL,
    parameter int H_ACTIVE     = PAL_H_ACTIVE,
    parameter int H_SYNC_START = PAL_H_SYNC_START,
    parameter int H_SYNC_LEN   = PAL_H_SYNC_LEN,
    parameter int V_TOTAL      = PAL_V_TOTAL,
    parameter int V_ACTIVE     = PAL_V_ACTIVE,
    parameter int V_SYNC_START = PAL_V_SYNC_START,
    parameter int V_SYNC_LINES = PAL_V_SYNC_LINES
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic [CNT_W-1:0] o_h,
    output logic [CNT_W-1:0] o_v,
    output logic             o_act,
    output logic             o_hs,
    output logic             o_vs,
    output logic             o_fs
);

    localparam logic [CNT_W-1:0] C_HT_M1 = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] C_VT_M1 = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] C_HA    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] C_VA    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] C_HSS   = CNT_W'(H_SYNC_START);
    localparam logic [CNT_W-1:0] C_HSE   = CNT_W'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [CNT_W-1:0] C_VSS   = CNT_W'(V_SYNC_START);
    localparam logic [CNT_W-1:0] C_VSE   = CNT_W'(V_SYNC_START + V_SYNC_LINES);
    localparam logic [CNT_W-1:0] C_VEND  =
        CNT_W'((V_SYNC_START + V_SYNC_LINES) % V_TOTAL);

    if (H_TOTAL > 511 || V_TOTAL > 511) begin : g_bad_total
        $error("raster totals must fit 9-bit counters");
    end
    if (H_ACTIVE > H_SYNC_START) begin : g_bad_hact
        $error("H_ACTIVE exceeds H_SYNC_START");
    end
    if (H_SYNC_START + H_SYNC_LEN > H_TOTAL) begin : g_bad_hsync
        $error("hsync runs past H_TOTAL");
    end
    if (V_SYNC_START + V_SYNC_LINES > V_TOTAL) begin : g_bad_vsync
        $error("vsync runs past V_TOTAL");
    end

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic             w_vs_start;
    logic             w_vs_mid;
    logic             w_vs_end;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == C_HT_M1) begin
            r_h <= '0;
            r_v <= (r_v == C_VT_M1) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    // Window is [(HSS,VSS), (HSS,VSS+LINES)); the end line may wrap to 0.
    assign w_vs_start = (r_v == C_VSS) && (r_h >= C_HSS);
    assign w_vs_mid   = (r_v > C_VSS) && (r_v < C_VSE);
    assign w_vs_end   = (r_v == C_VEND) && (r_h < C_HSS);

    assign o_h   = r_h;
    assign o_v   = r_v;
    assign o_act = (r_h < C_HA) && (r_v < C_VA);
    assign o_hs  = (r_h >= C_HSS) && (r_h < C_HSE);
    assign o_vs  = w_vs_start || w_vs_mid || w_vs_end;
    assign o_fs  = (r_h == '0) && (r_v == '0);

endmodule

// File: rtl/pal_video_timing_gen.sv
// PAL 15 kHz timing generator: counters, pixel request and a 2-stage
// pipeline that keeps blanked RGB and all syncs aligned with source latency.
module pal_video_timing_gen
    import video_pkg::*;
#(
    parameter int H_TOTAL      = PAL_H_TOTAL,
    parameter int H_ACTIVE     = PAL_H_ACTIVE,
    parameter int H_SYNC_START = PAL_H_SYNC_START,
    parameter int H_SYNC_LEN   = PAL_H_SYNC_LEN,
    parameter int V_TOTAL      = PAL_V_TOTAL,
    parameter int V_ACTIVE     = PAL_V_ACTIVE,
    parameter int V_SYNC_START = PAL_V_SYNC_START,
    parameter int V_SYNC_LINES = PAL_V_SYNC_LINES
) (
    input  logic       clkvideo,
    input  logic       rst,
    output logic       pix_req,
    output logic [8:0] pix_x,
    output logic [8:0] pix_y,
    input  logic [8:0] pix_rgb,
    output logic [2:0] ro,
    output logic [2:0] go,
    output logic [2:0] bo,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       csync_n,
    output logic       frame_start
);

    logic    w_act;
    logic    w_hs;
    logic    w_vs;
    logic    w_fs;
    rgb333_t w_pix;

    logic    r_act1;
    logic    r_hs1;
    logic    r_vs1;
    logic    r_fs1;
    rgb333_t r_rgb;
    logic    r_hsync_n;
    logic    r_vsync_n;
    logic    r_csync_n;
    logic    r_frame_start;

    video_sync_counter #(
        .H_TOTAL      (H_TOTAL),
        .H_ACTIVE     (H_ACTIVE),
        .H_SYNC_START (H_SYNC_START),
        .H_SYNC_LEN   (H_SYNC_LEN),
        .V_TOTAL      (V_TOTAL),
        .V_ACTIVE     (V_ACTIVE),
        .V_SYNC_START (V_SYNC_START),
        .V_SYNC_LINES (V_SYNC_LINES)
    ) u_cnt (
        .i_clk (clkvideo),
        .i_rst (rst),
        .o_h   (pix_x),
        .o_v   (pix_y),
        .o_act (w_act),
        .o_hs  (w_hs),
        .o_vs  (w_vs),
        .o_fs  (w_fs)
    );

    assign pix_req = w_act;
    assign w_pix   = rgb333_t'(pix_rgb);

    // Clearing both stages on reset means no stale sync can leak out.
    always_ff @(posedge clkvideo) begin
        if (rst) begin
            r_act1        <= 1'b0;
            r_hs1         <= 1'b0;
            r_vs1         <= 1'b0;
            r_fs1         <= 1'b0;
            r_rgb         <= '0;
            r_hsync_n     <= 1'b1;
            r_vsync_n     <= 1'b1;
            r_csync_n     <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_act1        <= w_act;
            r_hs1         <= w_hs;
            r_vs1         <= w_vs;
            r_fs1         <= w_fs;
            r_rgb         <= r_act1 ? w_pix : '0;
            r_hsync_n     <= ~r_hs1;
            r_vsync_n     <= ~r_vs1;
            r_csync_n     <= ~(r_hs1 ^ r_vs1);
            r_frame_start <= r_fs1;
        end
    end

    assign ro          = r_rgb.r;
    assign go          = r_rgb.g;
    assign bo          = r_rgb.b;
    assign hsync_n     = r_hsync_n;
    assign vsync_n     = r_vsync_n;
    assign csync_n     = r_csync_n;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_pal_video_timing_gen.sv
// Directed bench: full PAL timing for line-level checks, plus a shrunken
// raster instance so frame, vsync and mid-frame reset fit a short run.
module tb_pal_video_timing_gen;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance A: default PAL timing
    logic       rst_a;
    logic       req_a;
    logic [8:0] px_a, py_a, src_a;
    logic [2:0] ro_a, go_a, bo_a;
    logic       hs_a, vs_a, cs_a, fs_a;
    int         mode_a;

    pal_video_timing_gen u_a (
        .clkvideo    (clk),
        .rst         (rst_a),
        .pix_req     (req_a),
        .pix_x       (px_a),
        .pix_y       (py_a),
        .pix_rgb     (src_a),
        .ro          (ro_a),
        .go          (go_a),
        .bo          (bo_a),
        .hsync_n     (hs_a),
        .vsync_n     (vs_a),
        .csync_n     (cs_a),
        .frame_start (fs_a)
    );

    always @(posedge clk) begin
        case (mode_a)
            0:       src_a <= {px_a[2:0], py_a[2:0], 3'b101};
            1:       src_a <= 9'h1FF;
            default: src_a <= req_a ? 9'h1FF : 9'bx;
        endcase
    end

    // Instance B: 24 x 12 raster, hsync 18..20, vsync from (18,9) to (18,11)
    logic       rst_b;
    logic       req_b;
    logic [8:0] px_b, py_b, src_b;
    logic [2:0] ro_b, go_b, bo_b;
    logic       hs_b, vs_b, cs_b, fs_b;

    pal_video_timing_gen #(
        .H_TOTAL      (24),
        .H_ACTIVE     (16),
        .H_SYNC_START (18),
        .H_SYNC_LEN   (3),
        .V_TOTAL      (12),
        .V_ACTIVE     (8),
        .V_SYNC_START (9),
        .V_SYNC_LINES (2)
    ) u_b (
        .clkvideo    (clk),
        .rst         (rst_b),
        .pix_req     (req_b),
        .pix_x       (px_b),
        .pix_y       (py_b),
        .pix_rgb     (src_b),
        .ro          (ro_b),
        .go          (go_b),
        .bo          (bo_b),
        .hsync_n     (hs_b),
        .vsync_n     (vs_b),
        .csync_n     (cs_b),
        .frame_start (fs_b)
    );

    always @(posedge clk) src_b <= 9'h1FF;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int hl, nz, first_hl, ones, zeros, xs;
        int vl, csl, cserr, fsc, ved, vbad, vfall, vrise, n;
        logic pv, ph, found;

        rst_a = 1'b1;
        rst_b = 1'b1;
        mode_a = 0;
        adv(3);

        chk("rst_rgb", {ro_a, go_a, bo_a}, 0);
        chk("rst_hs", hs_a, 1);
        chk("rst_vs", vs_a, 1);
        chk("rst_cs", cs_a, 1);
        chk("rst_fs", fs_a, 0);
        chk("rst_pxy", {px_a, py_a}, 0);
        chk("rst_req", req_a, 1);

        rst_a = 1'b0;
        adv(1);
        chk("lat1_fs", fs_a, 0);
        chk("lat1_rgb", {ro_a, go_a, bo_a}, 0);
        adv(1);
        chk("p00_rgb", {ro_a, go_a, bo_a}, 9'o005);
        chk("p00_fs", fs_a, 1);
        adv(1);
        chk("p10_rgb", {ro_a, go_a, bo_a}, 9'o105);
        chk("p10_fs", fs_a, 0);
        adv(254);
        chk("p255_rgb", {ro_a, go_a, bo_a}, 9'o705);
        adv(1);
        chk("p256_blank", {ro_a, go_a, bo_a}, 0);
        adv(47);
        chk("h303_hs", hs_a, 1);
        adv(1);
        chk("h304_hs", hs_a, 0);
        chk("h304_cs", cs_a, 0);
        adv(27);
        chk("h331_hs", hs_a, 0);
        adv(1);
        chk("h332_hs", hs_a, 1);
        adv(52);
        chk("line1_rgb", {ro_a, go_a, bo_a}, 9'o015);
        chk("line1_fs", fs_a, 0);

        hl = 0; nz = 0; first_hl = -1;
        for (int i = 0; i < 384; i++) begin
            if (hs_a == 1'b0) begin
                hl++;
                if (first_hl < 0) first_hl = i;
            end
            if ({ro_a, go_a, bo_a} != 9'd0) nz++;
            adv(1);
        end
        chk("l1_hs_low", hl, 28);
        chk("l1_hs_fall", first_hl, 304);
        chk("l1_active", nz, 256);
        chk("l2_start_rgb", {ro_a, go_a, bo_a}, 9'o025);

        mode_a = 2;
        adv(384);
        ones = 0; zeros = 0; xs = 0;
        for (int i = 0; i < 384; i++) begin
            if ((^{ro_a, go_a, bo_a}) === 1'bx) xs++;
            else if ({ro_a, go_a, bo_a} == 9'h1FF) ones++;
            else if ({ro_a, go_a, bo_a} == 9'h000) zeros++;
            adv(1);
        end
        chk("xblank_x", xs, 0);
        chk("xblank_ones", ones, 256);
        chk("xblank_zero", zeros, 128);

        mode_a = 1;
        ones = 0; zeros = 0;
        for (int i = 0; i < 384; i++) begin
            if ({ro_a, go_a, bo_a} === 9'h1FF) ones++;
            if ({ro_a, go_a, bo_a} === 9'h000) zeros++;
            adv(1);
        end
        chk("allones_ones", ones, 256);
        chk("allones_zero", zeros, 128);

        rst_b = 1'b0;
        adv(1);
        chk("b_lat1_fs", fs_b, 0);
        adv(1);
        chk("b_p00_fs", fs_b, 1);
        chk("b_p00_rgb", {ro_b, go_b, bo_b}, 9'h1FF);

        vl = 0; hl = 0; csl = 0; cserr = 0; nz = 0; fsc = 0;
        ved = 0; vbad = 0; vfall = -1; vrise = -1;
        pv = 1'b1; ph = 1'b1;
        for (int i = 0; i < 288; i++) begin
            if (!vs_b) vl++;
            if (!hs_b) hl++;
            if (!cs_b) csl++;
            if (cs_b !== (vs_b ? hs_b : ~hs_b)) cserr++;
            if ({ro_b, go_b, bo_b} != 9'd0) nz++;
            if (fs_b) fsc++;
            if (vs_b != pv) begin
                ved++;
                if (!(ph && !hs_b)) vbad++;
                if (!vs_b) vfall = i;
                else vrise = i;
            end
            pv = vs_b;
            ph = hs_b;
            adv(1);
        end
        chk("b_vs_low", vl, 48);
        chk("b_hs_low", hl, 36);
        chk("b_cs_low", csl, 72);
        chk("b_cs_rule", cserr, 0);
        chk("b_active", nz, 128);
        chk("b_fs_count", fsc, 1);
        chk("b_vs_edges", ved, 2);
        chk("b_vs_on_hs", vbad, 0);
        chk("b_vs_fall_t", vfall, 234);
        chk("b_vs_rise_t", vrise, 282);
        chk("b_period", fs_b, 1);

        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            if (px_b == 9'd20 && py_b == 9'd9) found = 1'b1;
            else adv(1);
        end
        chk("b_reach_rst_pt", found, 1);
        chk("pre_rst_hs", hs_b, 0);
        chk("pre_rst_vs", vs_b, 0);
        chk("pre_rst_cs", cs_b, 1);

        rst_b = 1'b1;
        adv(1);
        chk("mrst_syncs", {hs_b, vs_b, cs_b}, 3'b111);
        chk("mrst_rgb", {ro_b, go_b, bo_b}, 0);
        chk("mrst_fs", fs_b, 0);
        chk("mrst_pxy", {px_b, py_b}, 0);
        rst_b = 1'b0;
        adv(1);
        chk("mrst_lat1_syncs", {hs_b, vs_b, cs_b}, 3'b111);
        chk("mrst_lat1_fs", fs_b, 0);
        adv(1);
        chk("mrst_fs", fs_b, 1);
        chk("mrst_rgb00", {ro_b, go_b, bo_b}, 9'h1FF);

        n = 0; vl = 0;
        do begin
            adv(1);
            n++;
            if (!vs_b) vl++;
        end while (!fs_b && n < 400);
        chk("mrst_period", n, 288);
        chk("mrst_vs_low", vl, 48);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
